// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared arbiter state encoding and owner IDs
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } arb_state_t;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_DM = 1'b1;

  function automatic arb_state_t busy_state(input logic owner);
    return (owner == OWNER_DM) ? BUSY_DM : BUSY_IF;
  endfunction

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// rtl/mem_arb_starve_cnt.sv - consecutive dm-grant counter used to let a waiting fetch through
module mem_arb_starve_cnt #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req,
  input  logic if_grant,
  input  logic dm_grant,
  output logic starved
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] cnt;

  // Saturates at the limit; the next arbitration then hands the bus to IF, which clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!if_req || if_grant) begin
      cnt <= '0;
    end else if (dm_grant && (cnt != CW'(STARVE_MAX))) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign starved = (cnt == CW'(STARVE_MAX));

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter onto one shared memory port
// Optional starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter
  import riscv_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t state;
  logic       pick_if;
  logic       pick_dm;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic starved;

  mem_arb_starve_cnt #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .if_grant ((state == IDLE) && pick_if),
    .dm_grant ((state == IDLE) && pick_dm),
    .starved  (starved)
  );

  assign pick_if = if_req && (!dm_req || starved);
`else
  assign pick_if = if_req && !dm_req;
`endif

  assign pick_dm = dm_req && !pick_if;

  // Bus operands are captured once at grant so requesters may change them afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      if_gnt    <= 1'b0;
      if_done   <= 1'b0;
      if_rdata  <= '0;
      dm_gnt    <= 1'b0;
      dm_done   <= 1'b0;
      dm_rdata  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if_gnt  <= 1'b0;
      dm_gnt  <= 1'b0;
      if_done <= 1'b0;
      dm_done <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_if) begin
            state     <= busy_state(OWNER_IF);
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            if_gnt    <= 1'b1;
          end else if (pick_dm) begin
            state     <= busy_state(OWNER_DM);
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            dm_gnt    <= 1'b1;
          end
        end
        BUSY_IF: begin
          if (mem_ack) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            if_rdata <= mem_rdata;
            if_done  <= 1'b1;
          end
        end
        BUSY_DM: begin
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            if (!mem_we) begin
              dm_rdata <= mem_rdata;
            end
            dm_done <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a behavioural reference model
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SM = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req, dm_req, dm_we, mem_ack;
  logic [AW-1:0] if_addr, dm_addr;
  logic [DW-1:0] dm_wdata, mem_rdata;
  logic          if_gnt, if_done, dm_gnt, dm_done, mem_req, mem_we;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_done(dm_done), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
    mem_ack = 0; mem_rdata = '0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst_n = 0;
    step(); step();
    rst_n = 1;
    step();
  endtask

  task automatic test_reset;
    idle_inputs();
    rst_n = 0;
    step(); step();
    checks++; if ({mem_req, mem_we, if_gnt, if_done, dm_gnt, dm_done} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 000000", {mem_req, mem_we, if_gnt, if_done, dm_gnt, dm_done}); end
    checks++; if ({mem_addr, mem_wdata} !== '0) begin
      errors++; $display("FAIL reset_bus: got addr %h wdata %h expected 0", mem_addr, mem_wdata); end
    checks++; if ({if_rdata, dm_rdata} !== '0) begin
      errors++; $display("FAIL reset_rdata: got %h %h expected 0", if_rdata, dm_rdata); end
    if_req = 1; dm_req = 1;
    step();
    checks++; if ({mem_req, if_gnt, dm_gnt} !== 3'b0) begin
      errors++; $display("FAIL reset_hold: got %b expected 000", {mem_req, if_gnt, dm_gnt}); end
    idle_inputs();
    rst_n = 1;
    step();
  endtask

  task automatic test_fetch_read;
    if_req = 1; if_addr = 32'h100;
    step();
    checks++; if ({if_gnt, dm_gnt, mem_req, mem_we} !== 4'b1010) begin
      errors++; $display("FAIL fetch_grant: got gnt/dgnt/req/we %b expected 1010", {if_gnt, dm_gnt, mem_req, mem_we}); end
    checks++; if (mem_addr !== 32'h100) begin
      errors++; $display("FAIL fetch_addr: got %h expected 00000100", mem_addr); end
    if_req = 0; if_addr = 32'h999;
    step();
    checks++; if ({if_gnt, mem_req} !== 2'b01 || mem_addr !== 32'h100) begin
      errors++; $display("FAIL fetch_hold: got gnt/req %b addr %h expected 01 00000100", {if_gnt, mem_req}, mem_addr); end
    step();
    mem_ack = 1; mem_rdata = 32'h00500093;
    step();
    checks++; if ({if_done, dm_done, mem_req} !== 3'b100) begin
      errors++; $display("FAIL fetch_done: got done/ddone/req %b expected 100", {if_done, dm_done, mem_req}); end
    checks++; if (if_rdata !== 32'h00500093) begin
      errors++; $display("FAIL fetch_rdata: got %h expected 00500093", if_rdata); end
    mem_ack = 0; mem_rdata = 32'h0;
    step();
    checks++; if (if_done !== 1'b0 || if_rdata !== 32'h00500093) begin
      errors++; $display("FAIL fetch_after: got done %b rdata %h expected 0 00500093", if_done, if_rdata); end
  endtask

  task automatic test_dm_priority;
    if_req = 1; if_addr = 32'h104;
    dm_req = 1; dm_we = 1; dm_addr = 32'h200; dm_wdata = 32'hDEADBEEF;
    step();
    checks++; if ({dm_gnt, if_gnt, mem_we} !== 3'b101) begin
      errors++; $display("FAIL prio_grant: got dgnt/ignt/we %b expected 101", {dm_gnt, if_gnt, mem_we}); end
    checks++; if (mem_addr !== 32'h200 || mem_wdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL prio_bus: got %h %h expected 00000200 deadbeef", mem_addr, mem_wdata); end
    dm_req = 0; dm_we = 0; dm_wdata = '0;
    step();
    checks++; if ({mem_req, mem_we} !== 2'b11 || mem_wdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL prio_stable: got req/we %b wdata %h expected 11 deadbeef", {mem_req, mem_we}, mem_wdata); end
    mem_ack = 1; mem_rdata = 32'h12345678;
    step();
    checks++; if ({dm_done, if_gnt, mem_req} !== 3'b100) begin
      errors++; $display("FAIL prio_done: got ddone/ignt/req %b expected 100", {dm_done, if_gnt, mem_req}); end
    checks++; if (dm_rdata !== 32'h0) begin
      errors++; $display("FAIL prio_wr_rdata: got %h expected 00000000", dm_rdata); end
    mem_ack = 0;
    step();
    checks++; if (if_gnt !== 1'b1 || mem_addr !== 32'h104 || mem_we !== 1'b0) begin
      errors++; $display("FAIL prio_if_next: got gnt %b addr %h we %b expected 1 00000104 0", if_gnt, mem_addr, mem_we); end
    if_req = 0;
    step();
    mem_ack = 1; mem_rdata = 32'hA5A50001;
    step();
    checks++; if (if_done !== 1'b1 || if_rdata !== 32'hA5A50001) begin
      errors++; $display("FAIL prio_if_done: got done %b rdata %h expected 1 a5a50001", if_done, if_rdata); end
    mem_ack = 0;
    step();
  endtask

  task automatic test_ack_in_idle;
    mem_ack = 1; mem_rdata = 32'hCAFEF00D;
    step(); step();
    checks++; if ({if_done, dm_done, mem_req} !== 3'b000) begin
      errors++; $display("FAIL idle_ack_ctrl: got %b expected 000", {if_done, dm_done, mem_req}); end
    checks++; if (if_rdata !== 32'hA5A50001 || dm_rdata !== 32'h0) begin
      errors++; $display("FAIL idle_ack_rdata: got %h %h expected a5a50001 00000000", if_rdata, dm_rdata); end
    mem_ack = 0;
    step();
  endtask

  task automatic test_reset_abort;
    dm_req = 1; dm_we = 0; dm_addr = 32'h300;
    step();
    checks++; if (dm_gnt !== 1'b1) begin
      errors++; $display("FAIL abort_grant: got %b expected 1", dm_gnt); end
    dm_req = 0;
    step();
    #2 rst_n = 0;
    #1;
    checks++; if (mem_req !== 1'b0) begin
      errors++; $display("FAIL abort_async: got mem_req %b expected 0", mem_req); end
    mem_ack = 1; mem_rdata = 32'h77;
    step();
    mem_ack = 0;
    #2 rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (dm_done !== 1'b0 || mem_req !== 1'b0) begin
        errors++; $display("FAIL abort_quiet: got done %b req %b expected 0 0", dm_done, mem_req); end
    end
    if_req = 1; if_addr = 32'h400;
    step();
    checks++; if (if_gnt !== 1'b1) begin
      errors++; $display("FAIL abort_idle: got if_gnt %b expected 1", if_gnt); end
    if_req = 0;
    step();
    mem_ack = 1;
    step();
    mem_ack = 0;
    step();
  endtask

  task automatic test_starvation;
    int got[$];
    int bc = 0;
    int streak = 0;
    int exp_w;
    do_reset();
    dm_req = 1; dm_we = 0; dm_addr = 32'h500; if_req = 1; if_addr = 32'h600;
    for (int cyc = 0; cyc < 150 && got.size() < 10; cyc++) begin
      step();
      if (if_gnt) got.push_back(1);
      if (dm_gnt) got.push_back(0);
      if (mem_req) bc++; else bc = 0;
      mem_ack = mem_req && (bc == 2);
      mem_rdata = $urandom;
    end
    checks++; if (got.size() != 10) begin
      errors++; $display("FAIL starve_timeout: got %0d grants expected 10", got.size()); end
    for (int k = 0; k < got.size(); k++) begin
      exp_w = (GUARD && streak == SM) ? 1 : 0;
      if (exp_w == 1) streak = 0; else streak++;
      checks++; if (got[k] != exp_w) begin
        errors++; $display("FAIL starve_seq[%0d]: got owner %0d expected %0d", k, got[k], exp_w); end
    end
    do_reset();
  endtask

  task automatic test_random_traffic;
    bit busy = 0, own_dm = 0, g_if, g_dm, d_if, d_dm;
    int bc = 0, streak = 0;
    logic [AW-1:0] e_addr = '0;
    logic          e_we = 0;
    logic [DW-1:0] e_wdata = '0, e_if_rd = '0, e_dm_rd = '0;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!if_req && $urandom_range(2) == 0) begin if_req = 1; if_addr = $urandom; end
      else if (if_req && $urandom_range(15) == 0) if_req = 0;
      if (!dm_req && $urandom_range(2) == 0) begin
        dm_req = 1; dm_we = $urandom_range(1); dm_addr = $urandom; dm_wdata = $urandom;
      end else if (dm_req && $urandom_range(15) == 0) dm_req = 0;
      if (busy && bc >= 2 && $urandom_range(1) == 0) mem_ack = 1;
      else if (!busy && $urandom_range(5) == 0) mem_ack = 1;
      else mem_ack = 0;
      mem_rdata = $urandom;
      g_if = 0; g_dm = 0; d_if = 0; d_dm = 0;
      if (!busy) begin
        if (if_req && (!dm_req || (GUARD && streak == SM))) g_if = 1;
        else if (dm_req) g_dm = 1;
        if (g_if) begin busy = 1; own_dm = 0; e_addr = if_addr; e_we = 0; bc = 1; end
        if (g_dm) begin busy = 1; own_dm = 1; e_addr = dm_addr; e_we = dm_we; e_wdata = dm_wdata; bc = 1; end
      end else if (mem_ack) begin
        busy = 0;
        if (own_dm) begin d_dm = 1; if (!e_we) e_dm_rd = mem_rdata; end
        else begin d_if = 1; e_if_rd = mem_rdata; end
      end else begin
        bc++;
      end
      if (!if_req || g_if) streak = 0; else if (g_dm) streak++;
      step();
      checks++; if ({if_gnt, dm_gnt} !== {g_if, g_dm}) begin
        errors++; $display("FAIL rnd_gnt@%0d: got %b expected %b", cyc, {if_gnt, dm_gnt}, {g_if, g_dm}); end
      checks++; if ({if_done, dm_done} !== {d_if, d_dm}) begin
        errors++; $display("FAIL rnd_done@%0d: got %b expected %b", cyc, {if_done, dm_done}, {d_if, d_dm}); end
      checks++; if (mem_req !== busy) begin
        errors++; $display("FAIL rnd_req@%0d: got %b expected %b", cyc, mem_req, busy); end
      if (busy) begin
        checks++; if (mem_addr !== e_addr || mem_we !== e_we) begin
          errors++; $display("FAIL rnd_bus@%0d: got %h/%b expected %h/%b", cyc, mem_addr, mem_we, e_addr, e_we); end
        if (own_dm && e_we) begin
          checks++; if (mem_wdata !== e_wdata) begin
            errors++; $display("FAIL rnd_wdata@%0d: got %h expected %h", cyc, mem_wdata, e_wdata); end
        end
      end
      checks++; if (if_rdata !== e_if_rd || dm_rdata !== e_dm_rd) begin
        errors++; $display("FAIL rnd_rdata@%0d: got %h/%h expected %h/%h", cyc, if_rdata, dm_rdata, e_if_rd, e_dm_rd); end
      if (g_if) if_req = 0;
      if (g_dm) dm_req = 0;
    end
    do_reset();
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    test_reset();
    test_fetch_read();
    test_dm_priority();
    test_ack_in_idle();
    test_reset_abort();
    test_starvation();
    test_random_traffic();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
